// File: rtl/cpu_pkg.sv
// Shared opcode, instruction-field and state definitions for the
// operand issue stage and its register file.
package cpu_pkg;

    localparam int OP_W  = 5;
    localparam int RA_W  = 3;
    localparam int IM_W  = 3;
    localparam int INS_W = 16;

    localparam int OP_HI = 15;
    localparam int OP_LO = 11;
    localparam int RD_HI = 10;
    localparam int RD_LO = 8;
    localparam int RS_HI = 7;
    localparam int RS_LO = 5;
    localparam int IM_HI = 4;
    localparam int IM_LO = 2;

    localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADD   = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND   = 5'b00010;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b00011;
    localparam logic [OP_W-1:0] OP_OR    = 5'b00100;
    localparam logic [OP_W-1:0] OP_XOR   = 5'b00101;
    localparam logic [OP_W-1:0] OP_MOV   = 5'b00110;
    localparam logic [OP_W-1:0] OP_NOT   = 5'b01000;
    localparam logic [OP_W-1:0] OP_SAR   = 5'b01001;
    localparam logic [OP_W-1:0] OP_SLR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_SAL   = 5'b01011;
    localparam logic [OP_W-1:0] OP_SLL   = 5'b01100;
    localparam logic [OP_W-1:0] OP_ROL   = 5'b01101;
    localparam logic [OP_W-1:0] OP_ROR   = 5'b01110;
    localparam logic [OP_W-1:0] OP_SHOWR = 5'b11111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    function automatic logic writes_back(input logic [OP_W-1:0] op);
        logic wb;
        wb = 1'b0;
        unique case (1'b1)
            (op >= OP_ADD) && (op <= OP_MOV): wb = 1'b1;
            (op >= OP_NOT) && (op <= OP_ROR): wb = 1'b1;
            default:                          wb = 1'b0;
        endcase
        return wb;
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return writes_back(op) || (op == OP_NOP) || (op == OP_SHOWR);
    endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// 8x8 register file: two async read ports, one sync write port.
// OPERAND_ISSUE_DBG_PORT_EN adds a third async read port for debug.
module reg_file_8x8
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    output logic [DATA_W-1:0] rdata_a,
`ifdef OPERAND_ISSUE_DBG_PORT_EN
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [REG_CNT];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

`ifdef OPERAND_ISSUE_DBG_PORT_EN
    assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/operand_issue_stage.sv
// Decode/operand-fetch stage feeding the 8-bit ALU, one instr per 2 cycles.
// OPERAND_ISSUE_DBG_PORT_EN exposes a combinational register debug read.
module operand_issue_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [4:0]        alu_op,
    output logic [2:0]        alu_im,
    input  logic [DATA_W-1:0] alu_res,
`ifdef OPERAND_ISSUE_DBG_PORT_EN
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic [DATA_W-1:0] show_data,
    output logic              show_valid,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  retired
);

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [RA_W-1:0]   rd_q;
    logic [OP_W-1:0]   dec_op;
    logic [RA_W-1:0]   dec_rd;
    logic [RA_W-1:0]   dec_rs;
    logic [IM_W-1:0]   dec_im;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic              wb_en;
    logic              unused_rsvd;

    assign dec_op      = instr[OP_HI:OP_LO];
    assign dec_rd      = instr[RD_HI:RD_LO];
    assign dec_rs      = instr[RS_HI:RS_LO];
    assign dec_im      = instr[IM_HI:IM_LO];
    assign unused_rsvd = ^instr[1:0];

    assign instr_ready = (state == ST_IDLE);

    // illegal_op doubles as the "squashed" flag for the EXEC cycle
    assign wb_en = (state == ST_EXEC) && !illegal_op && writes_back(op_q);

    reg_file_8x8 #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_rf (
        .clock   (clock),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (rd_q),
        .wdata   (alu_res),
        .raddr_a (dec_rd),
        .rdata_a (rd_val),
`ifdef OPERAND_ISSUE_DBG_PORT_EN
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
`endif
        .raddr_b (dec_rs),
        .rdata_b (rs_val)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_NOP;
            rd_q       <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_op     <= OP_NOP;
            alu_im     <= '0;
            show_data  <= '0;
            show_valid <= 1'b0;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            show_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q       <= dec_op;
                        rd_q       <= dec_rd;
                        alu_im     <= dec_im;
                        alu_in1    <= rd_val;
                        alu_in2    <= rs_val;
                        illegal_op <= !is_legal(dec_op);
                        alu_op     <= is_legal(dec_op) ? dec_op : OP_NOP;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state      <= ST_IDLE;
                    alu_op     <= OP_NOP;
                    illegal_op <= 1'b0;
                    if (!illegal_op) begin
                        retired <= retired + CNT_W'(1);
                    end
                    if (!illegal_op && (op_q == OP_SHOWR)) begin
                        show_data  <= alu_res;
                        show_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Scoreboard bench for operand_issue_stage: directed vectors feed queues,
// a negedge monitor pops and compares every EXEC cycle and show pulse.
module tb_operand_issue_stage;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic [4:0]  alu_op;
    logic [2:0]  alu_im;
    logic [7:0]  alu_res = '0;
    logic [7:0]  show_data;
    logic        show_valid;
    logic        illegal_op;
    logic [15:0] retired;
`ifdef OPERAND_ISSUE_DBG_PORT_EN
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
`endif

    operand_issue_stage dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_op      (alu_op),
        .alu_im      (alu_im),
        .alu_res     (alu_res),
`ifdef OPERAND_ISSUE_DBG_PORT_EN
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
`endif
        .show_data   (show_data),
        .show_valid  (show_valid),
        .illegal_op  (illegal_op),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] in1;
        logic [7:0] in2;
        logic [4:0] op;
        logic [2:0] im;
        logic       ill;
    } exp_t;

    exp_t       q[$];
    logic [7:0] sq[$];
    logic [7:0] mdl[8];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_acc = 0;
    int         prev_acc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (instr_ready === 1'b0) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL exec_unexpected: got EXEC cycle, expected none");
            end else begin
                n_chk--;
                e = q.pop_front();
                check("exec_in1", alu_in1, e.in1);
                check("exec_in2", alu_in2, e.in2);
                check("exec_op", alu_op, e.op);
                check("exec_im", alu_im, e.im);
                check("exec_illegal", illegal_op, e.ill);
            end
        end else if (instr_ready === 1'b1) begin
            check("idle_alu_op", alu_op, 0);
            check("idle_illegal", illegal_op, 0);
        end
        if (show_valid === 1'b1) begin
            n_chk++;
            if (sq.size() == 0) begin
                n_fail++;
                $display("FAIL show_unexpected: got show_valid=1, expected 0");
            end else begin
                n_chk--;
                check("show_data", show_data, sq.pop_front());
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] im,
                         input logic [7:0] res, input bit hold,
                         input bit commit);
        exp_t e;
        bit   legal;
        instr       = {op, rd, rs, im, 2'b10};
        instr_valid = 1'b1;
        if (instr_ready !== 1'b1) @(negedge clock);
        @(posedge clock);
        #1;
        prev_acc = last_acc;
        last_acc = cyc;
        alu_res  = res;
        legal = (op != 5'b00111) && ((op <= 5'b01110) || (op == 5'b11111));
        e.in1 = mdl[rd];
        e.in2 = mdl[rs];
        e.op  = legal ? op : 5'b00000;
        e.im  = im;
        e.ill = !legal;
        q.push_back(e);
        if (commit && legal) begin
            if (op == 5'b11111) sq.push_back(res);
            else if (op != 5'b00000) mdl[rd] = res;
        end
        @(negedge clock);
        if (!hold) instr_valid = 1'b0;
    endtask

`ifdef OPERAND_ISSUE_DBG_PORT_EN
    task automatic check_regs();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check("dbg_reg", dbg_data, mdl[i]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_alu_op", alu_op, 0);
        check("rst_retired", retired, 0);
        check("rst_show_valid", show_valid, 0);
        check("rst_show_data", show_data, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_in1", alu_in1, 0);
        check("rst_in2", alu_in2, 0);
        check("rst_im", alu_im, 0);
`ifdef OPERAND_ISSUE_DBG_PORT_EN
        check_regs();
`endif

        issue(OP_ADD, 3'd0, 3'd1, 3'd0, 8'h05, 1'b0, 1'b1);
        issue(OP_MOV, 3'd2, 3'd0, 3'd0, 8'h05, 1'b0, 1'b1);
        @(negedge clock);
        check("t1_retired", retired, 2);
`ifdef OPERAND_ISSUE_DBG_PORT_EN
        check_regs();
`endif

        issue(OP_ADD, 3'd3, 3'd2, 3'd0, 8'h7F, 1'b0, 1'b1);
        issue(OP_SHOWR, 3'd3, 3'd3, 3'd0, 8'h7F, 1'b0, 1'b1);
        @(negedge clock);
        check("t2_retired", retired, 4);
        check("t2_show_data", show_data, 8'h7F);
        check("t2_show_pulse", show_valid, 1);
        @(negedge clock);
        check("t2_show_end", show_valid, 0);

        issue(5'b10101, 3'd1, 3'd2, 3'd0, 8'hEE, 1'b0, 1'b1);
        @(negedge clock);
        check("t3_retired", retired, 4);
        @(negedge clock);
        check("t3_no_show", show_valid, 0);
`ifdef OPERAND_ISSUE_DBG_PORT_EN
        check_regs();
`endif

        issue(OP_XOR, 3'd5, 3'd0, 3'd0, 8'h11, 1'b1, 1'b1);
        issue(OP_SUB, 3'd6, 3'd5, 3'd0, 8'h22, 1'b1, 1'b1);
        check("t4_gap1", last_acc - prev_acc, 2);
        issue(OP_ROL, 3'd7, 3'd6, 3'd3, 8'h33, 1'b1, 1'b1);
        check("t4_gap2", last_acc - prev_acc, 2);
        issue(OP_NOT, 3'd1, 3'd7, 3'd0, 8'h44, 1'b0, 1'b1);
        check("t4_gap3", last_acc - prev_acc, 2);
        @(negedge clock);
        check("t4_retired", retired, 8);
`ifdef OPERAND_ISSUE_DBG_PORT_EN
        check_regs();
`endif

        issue(OP_ADD, 3'd4, 3'd3, 3'd0, 8'h99, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        check("t5_retired", retired, 0);
        check("t5_ready", instr_ready, 1);
        check("t5_show_valid", show_valid, 0);
        check("t5_alu_op", alu_op, 0);
`ifdef OPERAND_ISSUE_DBG_PORT_EN
        check_regs();
`endif
        issue(OP_MOV, 3'd4, 3'd4, 3'd0, 8'h00, 1'b0, 1'b1);
        issue(OP_OR, 3'd5, 3'd3, 3'd0, 8'h0A, 1'b0, 1'b1);
        @(negedge clock);
        check("t5_retired_after", retired, 2);

        repeat (3) @(negedge clock);
        check("exec_queue_drained", q.size(), 0);
        check("show_queue_drained", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 8-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads two operands from an internal 8x8 register file and drives the ALU's operand, opcode and immediate inputs for one execute cycle.
- Writes the ALU result back to the destination register; SHOWR results are latched to a display output.

Parameters:
- DATA_W, 8, operand/result width; must match ALU width.
- REG_CNT, 8, register count; register address width is 3.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; ALU evaluates in the low phase, flags latch on posedge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction: [15:11] op, [10:8] rd, [7:5] rs, [4:2] im, [1:0] reserved/ignored.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  stage can accept; high only in IDLE.
- alu_in1  out  DATA_W  R[rd] captured at issue.
- alu_in2  out  DATA_W  R[rs] captured at issue.
- alu_op  out  5  opcode to ALU; 5'b00000 (NOP) when not executing.
- alu_im  out  3  shift/rotate amount.
- alu_res  in  DATA_W  ALU result.
- show_data  out  DATA_W  last SHOWR value.
- show_valid  out  1  one-cycle pulse when show_data updates.
- illegal_op  out  1  one-cycle pulse on an illegal opcode.
- retired  out  CNT_W  count of completed legal instructions.

Behaviour:
- Reset values: all registers 0; state IDLE; alu_in1, alu_in2 and alu_im 0; alu_op 5'b00000; instr_ready 1; show_data 0; show_valid 0; illegal_op 0; retired 0.
- States: IDLE and EXEC.
- Issue (IDLE, instr_valid && instr_ready at posedge):
  - Register op, rd and im.
  - Register alu_in1 = R[rd] and alu_in2 = R[rs].
  - Go to EXEC.
- EXEC lasts exactly one cycle. alu_op = latched op during the whole cycle, so the ALU computes in the low phase.
- EXEC -> IDLE at the next posedge. On that edge:
  - Writeback ops 00001-00110 and 01000-01110: R[rd] <= alu_res.
  - SHOWR (11111): show_data <= alu_res; show_valid = 1 for the following cycle; no writeback.
  - NOP (00000): no writeback; retired still increments.
  - retired increments for every legal op.
- Illegal ops: 00111 and 01111-11110.
  - Detected at issue; the stage goes to EXEC with alu_op forced to 00000 so ALU flags are preserved.
  - illegal_op pulses on the EXEC cycle.
  - No writeback and no retired increment.
- Throughput: one instruction per 2 cycles. instr_ready = 0 in EXEC; instr_valid during EXEC is ignored and must be held by the source.
- Issue-to-writeback latency: 2 posedges.
- Register reads happen at issue; EXEC->IDLE writeback then IDLE->EXEC issue are separate edges, so back-to-back dependent instructions read the updated value without forwarding.
- rd == rs is legal: both operands are the same register.
- Reserved bits [1:0] are ignored.
- retired wraps from 2^CNT_W-1 to 0 silently.
- Reset asserted in EXEC: pending writeback and show update are abandoned; all state returns to reset values on that edge.
- reset has priority over handshake.

Optional Feature:
- Macro: OPERAND_ISSUE_DBG_PORT_EN.
- Defined: adds input dbg_addr [2:0] and output dbg_data [DATA_W-1:0].
  - Combinational read dbg_data = R[dbg_addr], independent of state.
  - Reflects a writeback from the cycle after the edge.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants (OP_NOP, OP_ADD, OP_AND, OP_SUB, OP_OR, OP_XOR, OP_MOV, OP_NOT, OP_SAR, OP_SLR, OP_SAL, OP_SLL, OP_ROL, OP_ROR, OP_SHOWR);
  - instruction field bit positions;
  - state encoding (ST_IDLE, ST_EXEC);
  - a writes-back decode function.
- Sub-module: reg_file_8x8.
  - Two async read ports, one sync write port, synchronous reset clear.
  - Instantiated once.

Test Plan:
- Reset, then idle -> instr_ready=1, alu_op=00000, retired=0, all registers read 0 via the debug port.
- R0=0 and R1=0 after reset. Issue ADD rd=0, rs=1 with ALU stub returning 8'h05, then MOV rd=2, rs=0 -> R0=05, R2=05, retired=2, instr_ready low exactly on each EXEC cycle.
- Back-to-back dependent instructions: ADD rd=3 (res 8'h7F) then SHOWR rd=3 -> alu_in1=7F on the second EXEC, show_data=7F, show_valid a single-cycle pulse.
- Issue op 5'b10101 -> illegal_op one pulse, alu_op stays 00000, no register changes, retired unchanged.
- Hold instr_valid=1 continuously with 4 instructions -> accepted every 2nd cycle, none lost or duplicated, retired=4 after 8 cycles.
- Assert reset during EXEC of ADD rd=4 -> R4 stays 0, state IDLE, retired=0, show_valid=0.
